// File: rtl/prbs7_siso_if.sv
// prbs7_siso_if: serial bit stream into the PRBS7 checker and its lock/error status back out
interface prbs7_siso_if #(
    parameter int CNT_W = 8
);
    logic             ena;
    logic             din;
    logic             din_valid;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       state_o;

    modport master (
        output ena, din, din_valid, clear,
        input  locked, err_pulse, err_cnt, state_o
    );

    modport slave (
        input  ena, din, din_valid, clear,
        output locked, err_pulse, err_cnt, state_o
    );
endinterface

// File: rtl/prbs7_siso_checker.sv
// prbs7_siso_checker: self-synchronising PRBS7 (x^7+x^6+1) bit-error checker with lock FSM
module prbs7_siso_checker #(
    parameter int LOCK_LEN = 16,
    parameter int WIN_LOG2 = 6,
    parameter int MAX_ERR  = 4,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    prbs7_siso_if.slave bus
);
    localparam int WE_W = $clog2(MAX_ERR + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t              state;
    logic [6:0]          lfsr;
    logic [2:0]          fill;
    logic [7:0]          run;
    logic [WIN_LOG2-1:0] win_bits;
    logic [WE_W-1:0]     win_err;
    logic [CNT_W-1:0]    err_cnt;
    logic                err_pulse;
    logic                locked;

    logic                taken;
    logic                exp_bit;
    logic                mis;
    logic                lock_err;
    logic [6:0]          lfsr_din;
    logic [6:0]          lfsr_exp;
    logic [WE_W-1:0]     err_sum;

    // Per-bit decode: prediction from the local LFSR and the two candidate shift results
    always_comb begin
        taken    = bus.ena & bus.din_valid;
        exp_bit  = lfsr[6] ^ lfsr[5];
        mis      = bus.din ^ exp_bit;
        lock_err = (state == LOCKED) & mis;
        lfsr_din = {lfsr[5:0], bus.din};
        lfsr_exp = {lfsr[5:0], exp_bit};
        err_sum  = win_err + WE_W'(lock_err);
    end

    // Lock FSM with LFSR, fill/run/window counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            lfsr      <= '0;
            fill      <= '0;
            run       <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else if (bus.ena) begin
            err_pulse <= taken & lock_err;
            if (taken) begin
                case (state)
                    SEARCH: begin
                        lfsr <= lfsr_din;
                        if (fill < 3'd6) begin
                            fill <= fill + 3'd1;
                        end else begin
                            // an all-zero register would never leave zero, so keep sliding in bits
                            fill <= 3'd7;
                            if (lfsr_din != 7'd0) begin
                                state <= VERIFY;
                                run   <= '0;
                            end
                        end
                    end
                    VERIFY: begin
                        lfsr <= lfsr_exp;
                        if (mis) begin
                            state <= SEARCH;
                            fill  <= '0;
                        end else begin
                            run <= run + 8'd1;
                            if (run == 8'(LOCK_LEN - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        lfsr <= lfsr_exp;
                        if (mis && err_cnt != '1)
                            err_cnt <= err_cnt + CNT_W'(1);
                        if (err_sum == WE_W'(MAX_ERR)) begin
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            fill     <= '0;
                            win_err  <= '0;
                            win_bits <= '0;
                        end else begin
                            win_bits <= win_bits + WIN_LOG2'(1);
                            win_err  <= (&win_bits) ? '0 : err_sum;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        fill   <= '0;
                    end
                endcase
            end
            if (bus.clear) begin
                err_cnt  <= '0;
                win_err  <= '0;
                win_bits <= '0;
            end
        end
    end

    assign bus.locked    = locked;
    assign bus.err_pulse = err_pulse;
    assign bus.err_cnt   = err_cnt;
    assign bus.state_o   = state;
endmodule
